// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM word controller.
package sram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 10;

    localparam logic [3:0] WSTRB_NONE = 4'h0;
    localparam logic [3:0] WSTRB_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RESP,
        WRITE,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge: strobed bytes come from new_word, the rest from old_word.
module sram_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    // Select each byte lane independently by its strobe.
    always_comb begin
        merged = old_word;
        for (int unsigned k = 0; k < 4; k++) begin
            if (wstrb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_word_ctrl.sv
// PicoRV32 native memory bus to single-port word SRAM controller.
// Partial-word stores are done as read-modify-write since the SRAM has no
// byte enables. Optional macro SRAM_RDY_CHECK_EN adds a sticky sram_err output
// flagging sram_rdy=0 in the cycle after an SRAM access edge.
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic              sram_oen,
    input  logic [DATA_W-1:0] sram_q,
    input  logic              sram_rdy
`ifdef SRAM_RDY_CHECK_EN
    ,
    output logic              sram_err
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          wstrb_q;
    logic [DATA_W-1:0]   merged_word;
    logic                unused_bits;

    sram_byte_merge u_merge (
        .old_word (sram_q),
        .new_word (wdata_q),
        .wstrb    (wstrb_q),
        .merged   (merged_word)
    );

    // State register and request latches; latches load only on acceptance in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && mem_valid) begin
                addr_q  <= mem_addr[ADDR_W+1:2];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
        end
    end

    // Next-state and SRAM/bus output decode; outputs depend only on registered state.
    always_comb begin
        state_nxt = state;
        mem_ready = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_oen  = 1'b1;
        sram_d    = wdata_q;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_wstrb == WSTRB_NONE) begin
                        state_nxt = READ;
                    end else if (mem_wstrb == WSTRB_FULL) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = RMW_RD;
                    end
                end
            end
            READ: begin
                sram_cen  = 1'b0;
                sram_oen  = 1'b0;
                state_nxt = RESP;
            end
            RESP: begin
                // CEn held low: a rising CEn would clear Q before it is returned.
                sram_cen  = 1'b0;
                mem_ready = 1'b1;
                state_nxt = IDLE;
            end
            WRITE: begin
                sram_cen  = 1'b0;
                sram_wen  = 1'b0;
                state_nxt = DONE;
            end
            RMW_RD: begin
                sram_cen  = 1'b0;
                sram_oen  = 1'b0;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                sram_cen  = 1'b0;
                sram_wen  = 1'b0;
                sram_d    = merged_word;
                state_nxt = DONE;
            end
            DONE: begin
                mem_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sram_a    = addr_q;
    assign mem_rdata = sram_q;

`ifdef SRAM_RDY_CHECK_EN
    // Sticky error when the SRAM is not ready in the cycle after an access edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sram_err <= 1'b0;
        end else if ((state == RESP || state == RMW_WR || state == DONE) && !sram_rdy) begin
            sram_err <= 1'b1;
        end
    end

    assign unused_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`else
    assign unused_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0], sram_rdy};
`endif

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl with a behavioural SRAM model and an
// expected-read-data scoreboard.
module tb_sram_word_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [9:0]  sram_a;
    logic [31:0] sram_d;
    logic        sram_cen;
    logic        sram_wen;
    logic        sram_oen;
    logic [31:0] sram_q;
    logic        sram_rdy;
`ifdef SRAM_RDY_CHECK_EN
    logic        sram_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];
    logic [31:0] exp_q [$];

    always #5 CLK = ~CLK;

    sram_word_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_oen  (sram_oen),
        .sram_q    (sram_q),
        .sram_rdy  (sram_rdy)
`ifdef SRAM_RDY_CHECK_EN
        ,
        .sram_err  (sram_err)
`endif
    );

    // SRAM model: registered Q loaded on a read edge, cleared whenever CEn is high.
    always @(posedge CLK or posedge sram_cen) begin
        if (sram_cen) begin
            sram_q <= '0;
        end else if (sram_wen && !sram_oen) begin
            sram_q <= sram_mem[sram_a];
        end
    end

    // SRAM model: write on an enabled write edge.
    always @(posedge CLK) begin
        if (!sram_cen && !sram_wen) begin
            sram_mem[sram_a] <= sram_d;
        end
    end

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
        logic [31:0] r;
        r[7:0]   = strb[0] ? new_w[7:0]   : old_w[7:0];
        r[15:8]  = strb[1] ? new_w[15:8]  : old_w[15:8];
        r[23:16] = strb[2] ? new_w[23:16] : old_w[23:16];
        r[31:24] = strb[3] ? new_w[31:24] : old_w[31:24];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction, starting in an IDLE cycle just after a rising edge.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int exp_lat, input logic [9:0] exp_a);
        int          lat;
        bit          got;
        logic [9:0]  idx;
        logic [31:0] exp_rd;
        idx = addr[11:2];
        if (strb == 4'h0) begin
            exp_q.push_back(ref_mem[idx]);
        end else begin
            ref_mem[idx] = ref_merge(ref_mem[idx], wdata, strb);
        end
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        got = 1'b0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                chk("idle_cen", {31'b0, sram_cen}, 32'd1);
                chk("idle_ready", {31'b0, mem_ready}, 32'd0);
            end
            if (c == 1) begin
                chk("access_cen", {31'b0, sram_cen}, 32'd0);
                chk("access_addr", {22'b0, sram_a}, {22'b0, exp_a});
            end
            if (mem_ready) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        chk("ready_seen", {31'b0, got}, 32'd1);
        chk("latency", lat, exp_lat);
        if (strb == 4'h0 && exp_q.size() > 0) begin
            exp_rd = exp_q.pop_front();
            chk("rdata", mem_rdata, exp_rd);
        end
        @(posedge CLK);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    initial begin
        RST       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        sram_rdy  = 1'b1;

        // Reset held for two cycles.
        repeat (2) begin
            @(negedge CLK);
            chk("rst_cen", {31'b0, sram_cen}, 32'd1);
            chk("rst_wen", {31'b0, sram_wen}, 32'd1);
            chk("rst_oen", {31'b0, sram_oen}, 32'd1);
            chk("rst_ready", {31'b0, mem_ready}, 32'd0);
            chk("rst_addr", {22'b0, sram_a}, 32'd0);
        end
`ifdef SRAM_RDY_CHECK_EN
        chk("rst_err", {31'b0, sram_err}, 32'd0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Idle with no request: SRAM stays disabled.
        repeat (5) begin
            @(negedge CLK);
            chk("idle_no_enable", {31'b0, sram_cen}, 32'd1);
        end
        @(posedge CLK);
        #1;

        // Full write and read back.
        txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 10'd4);
        txn(32'h0000_0010, 32'h0, 4'h0, 2, 10'd4);

        // Partial write as read-modify-write.
        txn(32'h0000_0010, 32'h1122_3344, 4'hF, 2, 10'd4);
        txn(32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 3, 10'd4);
        txn(32'h0000_0010, 32'h0, 4'h0, 2, 10'd4);
        chk("rmw_ref", ref_mem[4], 32'h11BB_33DD);

        // Address aliasing above the word-address range.
        txn(32'h0000_1000, 32'h5A5A_5A5A, 4'hF, 2, 10'd0);
        txn(32'h0000_0000, 32'h0, 4'h0, 2, 10'd0);

        // Back-to-back: read then full write with no idle gap beyond the mandatory one.
        txn(32'h0000_0008, 32'h0BAD_F00D, 4'hF, 2, 10'd2);
        txn(32'h0000_0008, 32'h0, 4'h0, 2, 10'd2);
        txn(32'h0000_000C, 32'h1357_9BDF, 4'hF, 2, 10'd3);
        txn(32'h0000_000C, 32'h0, 4'h0, 2, 10'd3);

        // Reset during RMW_RD: aborted, word untouched, no ready.
        txn(32'h0000_0020, 32'hCAFE_0123, 4'hF, 2, 10'd8);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0020;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'b0011;
        @(posedge CLK);
        #1;
        chk("rmw_rd_cen", {31'b0, sram_cen}, 32'd0);
        chk("rmw_rd_oen", {31'b0, sram_oen}, 32'd0);
        RST = 1'b1;
        #1;
        chk("abort_cen", {31'b0, sram_cen}, 32'd1);
        chk("abort_ready", {31'b0, mem_ready}, 32'd0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        repeat (2) begin
            @(negedge CLK);
            chk("abort_hold_ready", {31'b0, mem_ready}, 32'd0);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("post_abort_ready", {31'b0, mem_ready}, 32'd0);
        end
        @(posedge CLK);
        #1;
        txn(32'h0000_0020, 32'h0, 4'h0, 2, 10'd8);

`ifdef SRAM_RDY_CHECK_EN
        // Sticky error flag on a not-ready SRAM, cleared only by reset.
        chk("err_clear", {31'b0, sram_err}, 32'd0);
        sram_rdy = 1'b0;
        txn(32'h0000_0010, 32'h0, 4'h0, 2, 10'd4);
        sram_rdy = 1'b1;
        @(negedge CLK);
        chk("err_set", {31'b0, sram_err}, 32'd1);
        @(posedge CLK);
        #1;
        txn(32'h0000_0010, 32'h2468_ACE0, 4'hF, 2, 10'd4);
        chk("err_sticky", {31'b0, sram_err}, 32'd1);
        RST = 1'b1;
        #1;
        chk("err_reset", {31'b0, sram_err}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
